// File: rtl/bcd_field_counter.sv
// One BCD field (sec/min/hour/day/month/year) of a clock/calendar chain.
// Supports tick/inc/dec with wrap, parallel load, clamp to a runtime bound, and registered cascade pulses.
module bcd_field_counter #(
    parameter int DIGITS    = 2,
    parameter int MIN_VAL   = 0,
    parameter int RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   max_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  at_max,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] RST_BCD = to_bcd(RESET_VAL);

    logic [W-1:0]    value_reg, value_next;
    logic            carry_reg, carry_next;
    logic            borrow_reg, borrow_next;
    logic            err_reg, err_next;

    logic [W-1:0]    max_s;
    logic [W-1:0]    inc_val;
    logic [W-1:0]    dec_val;
    logic [DIGITS:0] inc_c;
    logic [DIGITS:0] dec_b;
    logic [DIGITS-1:0] ld_digit_ok;

    assign inc_c[0] = 1'b1;
    assign dec_b[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d = value_reg[4*gi +: 4];
            // An illegal bound digit is treated as 9 so value can never pick up a non-BCD digit.
            assign max_s[4*gi +: 4] = (max_val[4*gi +: 4] > 4'd9) ? 4'd9 : max_val[4*gi +: 4];
            assign ld_digit_ok[gi]  = (load_val[4*gi +: 4] <= 4'd9);

            assign inc_val[4*gi +: 4] = !inc_c[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign inc_c[gi+1]        = inc_c[gi] & (d == 4'd9);
            assign dec_val[4*gi +: 4] = !dec_b[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign dec_b[gi+1]        = dec_b[gi] & (d == 4'd0);
        end
    endgenerate

    logic degenerate;
    logic load_ok;
    logic all_nine;

    assign degenerate = (max_s < MIN_BCD);
    assign load_ok    = (&ld_digit_ok) && (load_val >= MIN_BCD) && (load_val <= max_s);
    assign all_nine   = inc_c[DIGITS];

    always_comb begin
        value_next  = value_reg;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        err_next    = 1'b0;
        if (load) begin
            if (load_ok) begin
                value_next = load_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (inc && dec) begin
            value_next = value_reg;
        end else if (dec) begin
            borrow_next = 1'b1;
            if (degenerate) begin
                value_next = MIN_BCD;
            end else if (value_reg <= MIN_BCD) begin
                value_next = max_s;
            end else begin
                value_next  = dec_val;
                borrow_next = 1'b0;
            end
        end else if (inc || tick) begin
            // all_nine guards the top digit when the bound itself is malformed.
            if (value_reg >= max_s || all_nine) begin
                value_next = MIN_BCD;
                carry_next = 1'b1;
            end else begin
                value_next = inc_val;
            end
        end else if (degenerate) begin
            value_next = MIN_BCD;
        end else if (value_reg > max_s) begin
            value_next = max_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg  <= RST_BCD;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            value_reg  <= value_next;
            carry_reg  <= carry_next;
            borrow_reg <= borrow_next;
            err_reg    <= err_next;
        end
    end

    assign value      = value_reg;
    assign carry_out  = carry_reg;
    assign borrow_out = borrow_reg;
    assign load_err   = err_reg;
    assign at_max     = (value_reg == max_val);

endmodule

// File: doc/bcd_field_counter.md
Name: bcd_field_counter

Overview:
- Parametrised multi-digit BCD counter for one calendar or clock field (seconds, minutes, hours, day, month, year).
- Provides tick counting, set-mode increment and decrement with wrap, parallel load, and a runtime-programmable upper bound.
- Produces registered carry and borrow pulses so fields cascade: the carry of sec feeds the tick of min, and so on.
- Used next to the seven-segment decoders; the clock/calendar top instantiates one per field.

Parameters:
- DIGITS, 2, number of BCD digits; value width is 4*DIGITS.
- MIN_VAL, 0, lowest legal value as a decimal integer (1 for day/month, 0 for sec/min/hour).
- RESET_VAL, 0, value loaded on reset as a decimal integer; must satisfy MIN_VAL <= RESET_VAL.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle count-up strobe in run mode.
- inc  in  1  one-cycle set-mode increment strobe.
- dec  in  1  one-cycle set-mode decrement strobe.
- load  in  1  parallel-load strobe.
- load_val  in  4*DIGITS  BCD value to load.
- max_val  in  4*DIGITS  BCD upper bound, may change any cycle (for example 28/29/30/31 for day).
- value  out  4*DIGITS  current BCD value, registered.
- carry_out  out  1  registered pulse: an up-wrap happened at this edge.
- borrow_out  out  1  registered pulse: a down-wrap happened at this edge.
- at_max  out  1  combinational, value == max_val.
- load_err  out  1  registered pulse: a load was rejected.

Behaviour:
- Reset (rst high at a clk edge):
  - value <= BCD(RESET_VAL).
  - carry_out, borrow_out and load_err <= 0.
  - Reset overrides every other input in the same cycle. Asserting reset mid-operation discards any pending pulse.
- Latency: every operation updates value at the same edge it is sampled. Pulses are high for exactly the one cycle following that edge, aligned with the new value.
- Priority each cycle: load > (inc xor dec) > tick > clamp. inc and dec together is a no-op, and tick is ignored that cycle.
- Load:
  - Accepted if every digit of load_val is <= 9 and MIN_VAL <= load_val <= max_val.
  - If accepted, value <= load_val.
  - If rejected, value is held and load_err pulses.
  - A load never produces carry or borrow.
- Up step (tick, or inc alone):
  - If value >= max_val: value <= MIN_VAL and carry_out pulses.
  - Otherwise: BCD increment with internal digit ripple; a digit at 9 goes to 0 and carries into the next digit.
  - tick and inc share the same arithmetic. carry_out pulses for both sources, so the next field advances in set mode as well.
- Down step (dec alone):
  - If value <= MIN_VAL: value <= max_val and borrow_out pulses.
  - Otherwise: BCD decrement; a digit at 0 goes to 9 and borrows from the next digit.
- Clamp: if no other operation is active and value > max_val, then value <= max_val at the next edge, with no pulse. This covers a day value of 31 when the month changes to February.
- Degenerate bound: if max_val < MIN_VAL, value is forced to MIN_VAL. Up and down steps then hold MIN_VAL and still pulse carry/borrow.
- Comparisons: unsigned compares on the packed BCD bus, which are valid because max_val is required to be legal BCD. A max_val containing a digit > 9 is a caller error; value must still never hold a non-BCD digit.
- Wrap arithmetic never overflows 4*DIGITS bits. A top digit at 9 wraps only through the max_val rule.
- at_max is purely combinational from value and max_val. Use it for lookahead cascade, for example minute carry when seconds are at max and tick is high.

Test Plan:
- Reset and count up (DIGITS=2, MIN_VAL=0, RESET_VAL=0, max_val=8'h59):
  - rst high for 2 cycles -> value=8'h00 and all pulses 0.
  - 60 tick pulses -> value passes 09 -> 10 and reaches 59; the 60th tick gives value=00 with carry_out high for exactly 1 cycle.
- Set-mode wrap (max_val=8'h23, value=00):
  - dec -> value=23 and borrow_out pulses.
  - inc -> value=00 and carry_out pulses.
  - inc and dec in the same cycle -> value=00 and no pulse.
- Day field clamp (MIN_VAL=1, RESET_VAL=1):
  - Load 8'h31 with max_val=8'h31 -> value=31.
  - Change max_val to 8'h28 -> next cycle value=28 with no pulse.
  - tick -> value=01 and carry_out pulses.
- Load rejection (max_val=8'h12, MIN_VAL=1, value=05):
  - load_val=8'h1A -> load_err pulses and value stays 05.
  - load_val=8'h00 -> rejected.
  - load_val=8'h12 -> accepted, value=12.
- Priority:
  - load=1, inc=1, tick=1 in the same cycle with load_val=8'h07 -> value=07 and no carry.
  - rst together with load -> value=RESET_VAL.
- Four-digit year (DIGITS=4, RESET_VAL=2024, max_val=16'h9999):
  - Load 16'h0999 then tick -> value=1000 with no carry.
  - Load 16'h9999 then tick -> value=0000 and carry_out pulses.
